// File: rtl/ci_stim_link_rx.sv
// Serial link receiver: oversamples the stimulator's clk_out/data_out link and
// deserialises MSB-first frames. Optional even-parity bit: STIM_LINK_RX_PARITY_EN.
module ci_stim_link_rx #(
  parameter int FRAME_BITS   = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_link_clk,
  input  logic                  i_link_data,
  output logic [FRAME_BITS-1:0] o_frame_data,
  output logic                  o_frame_valid,
  output logic                  o_frame_err,
  output logic                  o_busy,
  output logic [7:0]            o_frame_cnt
);

`ifdef STIM_LINK_RX_PARITY_EN
  localparam int LEN = FRAME_BITS + 1;
`else
  localparam int LEN = FRAME_BITS;
`endif
  localparam int CW = $clog2(LEN + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [LEN-1:0]  r_shift, w_shift_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic            w_done, w_timeout, w_good;

  logic            r_link_clk_p0, r_link_clk_p1, r_link_clk_p2;
  logic            r_link_data_p0, r_link_data_p1;
  logic            w_rise, w_bit;

  logic [FRAME_BITS-1:0] r_frame_data;
  logic                  r_frame_valid, r_frame_err;
  logic [7:0]            r_frame_cnt;

  // Synchroniser stage: clock and data share the same depth so they stay aligned
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_link_clk_p0  <= 1'b0;
      r_link_clk_p1  <= 1'b0;
      r_link_clk_p2  <= 1'b0;
      r_link_data_p0 <= 1'b0;
      r_link_data_p1 <= 1'b0;
    end else begin
      r_link_clk_p0  <= i_link_clk;
      r_link_clk_p1  <= r_link_clk_p0;
      r_link_clk_p2  <= r_link_clk_p1;
      r_link_data_p0 <= i_link_data;
      r_link_data_p1 <= r_link_data_p0;
    end
  end

  assign w_rise    = r_link_clk_p1 & ~r_link_clk_p2;
  assign w_bit     = r_link_data_p1;
  assign w_cnt_inc = r_cnt + 1'b1;

  // Frame state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_timer_nxt = r_timer;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_shift_nxt = {{(LEN-1){1'b0}}, w_bit};
          w_cnt_nxt   = CW'(1);
          w_timer_nxt = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_rise) begin
          w_shift_nxt = {r_shift[LEN-2:0], w_bit};
          w_cnt_nxt   = w_cnt_inc;
          w_timer_nxt = '0;
          if (w_cnt_inc == CW'(LEN)) begin
            w_done      = 1'b1;
            w_state_nxt = S_DONE;
          end
        end else if (r_timer == TW'(IDLE_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef STIM_LINK_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero
  assign w_good = ~(^w_shift_nxt);
`else
  assign w_good = 1'b1;
`endif

  // Output stage: result lands in the DONE cycle, one cycle after the last rise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_valid <= w_done & w_good;
      r_frame_err   <= w_timeout | (w_done & ~w_good);
      if (w_done && w_good) begin
        r_frame_data <= w_shift_nxt[LEN-1 -: FRAME_BITS];
        r_frame_cnt  <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign o_frame_data  = r_frame_data;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_busy        = (r_state == S_SHIFT);

endmodule

// File: tb/tb_ci_stim_link_rx.sv
// Randomised bench for ci_stim_link_rx against a frame-level reference model.
module tb_ci_stim_link_rx;
  localparam int FB = 16;
`ifdef STIM_LINK_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          link_clk = 1'b0;
  logic          link_data = 1'b0;
  logic [FB-1:0] frame_data;
  logic          frame_valid, frame_err, busy;
  logic [7:0]    frame_cnt;

  always #5 clk = ~clk;

  ci_stim_link_rx #(.FRAME_BITS(FB), .IDLE_TIMEOUT(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_link_clk(link_clk), .i_link_data(link_data),
    .o_frame_data(frame_data), .o_frame_valid(frame_valid), .o_frame_err(frame_err),
    .o_busy(busy), .o_frame_cnt(frame_cnt));

  int            total = 0;
  int            bad = 0;
  int            n_err = 0;
  logic          prev_valid = 1'b0;
  logic [FB-1:0] got_q[$];
  logic [FB-1:0] exp_q[$];
  int            exp_cnt = 0;
  logic [FB-1:0] exp_data = '0;

  // Collects delivered frames and error pulses; valid/err must be exclusive single-cycle pulses
  always @(negedge clk) begin
    if (frame_valid) got_q.push_back(frame_data);
    if (frame_err) n_err++;
    if (frame_valid || frame_err) begin
      total++;
      if ((frame_valid && frame_err) || (frame_valid && prev_valid)) begin
        bad++;
        $display("FAIL pulse_shape valid=%0b err=%0b prev_valid=%0b required exclusive one-cycle pulses",
                 frame_valid, frame_err, prev_valid);
      end
    end
    prev_valid = frame_valid;
  end

  task automatic send_bit(input logic b, input int lo, input int hi);
    link_clk  = 1'b0;
    link_data = b;
    repeat (lo) @(negedge clk);
    link_clk = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic send_frame(input logic [FB-1:0] d, input logic flip, input logic rnd);
    int lo, hi;
    for (int i = FB - 1; i >= 0; i--) begin
      lo = rnd ? int'($urandom_range(3, 4)) : 4;
      hi = rnd ? int'($urandom_range(3, 4)) : 4;
      send_bit(d[i], lo, hi);
    end
    if (PAR != 0) send_bit((^d) ^ flip, 4, 4);
  endtask

  // Model of a good frame: delivered once, becomes the held word, bumps the wrapping count
  task automatic model_good(input logic [FB-1:0] d);
    exp_q.push_back(d);
    exp_data = d;
    exp_cnt  = (exp_cnt + 1) % 256;
  endtask

  task automatic do_reset();
    link_clk = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_cnt = 0;
    exp_data = '0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    logic b;
    rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b = 1'($urandom_range(0, 1));
      send_bit(b, 3, 3);
      total++;
      if ({frame_valid, frame_err, busy, frame_cnt, frame_data} !== '0) begin
        bad++;
        $display("FAIL reset_hold valid=%0b err=%0b busy=%0b cnt=%0d data=%h required all zero",
                 frame_valid, frame_err, busy, frame_cnt, frame_data);
      end
    end
    link_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({busy, frame_valid, frame_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_release busy=%0b valid=%0b cnt=%0d required 0", busy, frame_valid, frame_cnt);
    end
    got_q.delete();
  endtask

  task automatic test_good_frame();
    send_frame(16'hA5C3, 1'b0, 1'b0);
    model_good(16'hA5C3);
    repeat (6) @(negedge clk);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 16'hA5C3) begin
      bad++;
      $display("FAIL good_frame frames=%0d first=%h required 1 frame of a5c3", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0);
    end
    total++;
    if (frame_data !== exp_data || frame_cnt !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL good_frame_out data=%h cnt=%0d required data=%h cnt=%0d",
               frame_data, frame_cnt, exp_data, exp_cnt);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_latency();
    logic [FB-1:0] d;
    int            hit, n;
    d = 16'($urandom);
    hit = 0;
    n = 0;
    for (int i = FB - 1; i >= 1; i--) send_bit(d[i], 4, 4);
    if (PAR != 0) begin
      send_bit(d[0], 4, 4);
      link_data = ^d;
    end else begin
      link_data = d[0];
    end
    link_clk = 1'b0;
    repeat (4) @(negedge clk);
    link_clk = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (frame_valid) begin
        n++;
        hit = k;
      end
    end
    model_good(d);
    total++;
    if (n != 1 || hit != 3) begin
      bad++;
      $display("FAIL latency pulses=%0d at_cycle=%0d required 1 pulse at cycle 3", n, hit);
    end
    total++;
    if (frame_data !== d) begin
      bad++;
      $display("FAIL latency_data data=%h required %h", frame_data, d);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [FB-1:0] base;
    logic [FB-1:0] e;
    do_reset();
    base = 16'($urandom);
    for (int i = 0; i < 300; i++) begin
      send_frame(base + 16'(i), 1'b0, 1'b1);
      model_good(base + 16'(i));
    end
    repeat (8) @(negedge clk);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count frames=%0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e = exp_q[i];
      total++;
      if (got_q[i] !== e) begin
        bad++;
        $display("FAIL b2b_frame idx=%0d got=%h required %h", i, got_q[i], e);
      end
    end
    total++;
    if (frame_cnt !== 8'(exp_cnt) || frame_cnt !== 8'd44) begin
      bad++;
      $display("FAIL b2b_cnt cnt=%0d required 44", frame_cnt);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_short_frame();
    int e0;
    e0 = n_err;
    for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)), 4, 4);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL short_busy busy=%0b required 1", busy);
    end
    repeat (100) @(negedge clk);
    total++;
    if (n_err - e0 != 1 || got_q.size() != 0) begin
      bad++;
      $display("FAIL short_err err_pulses=%0d frames=%0d required 1 err, 0 frames", n_err - e0, got_q.size());
    end
    total++;
    if (frame_data !== exp_data || frame_cnt !== 8'(exp_cnt) || busy !== 1'b0) begin
      bad++;
      $display("FAIL short_hold data=%h cnt=%0d busy=%0b required data=%h cnt=%0d busy=0",
               frame_data, frame_cnt, busy, exp_data, exp_cnt);
    end
    send_frame(16'h1234, 1'b0, 1'b0);
    model_good(16'h1234);
    repeat (6) @(negedge clk);
    total++;
    if (got_q.size() != 1 || frame_data !== 16'h1234 || frame_cnt !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL short_recover frames=%0d data=%h cnt=%0d required 1 frame 1234 cnt=%0d",
               got_q.size(), frame_data, frame_cnt, exp_cnt);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stuck_link();
    int e0;
    e0 = n_err;
    repeat (150) @(negedge clk);
    link_clk = 1'b0;
    repeat (150) @(negedge clk);
    total++;
    if (n_err != e0 || busy !== 1'b0 || got_q.size() != 0) begin
      bad++;
      $display("FAIL stuck_link err_pulses=%0d busy=%0b frames=%0d required none",
               n_err - e0, busy, got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), 4, 4);
    rst_n = 1'b0;
    link_clk = 1'b0;
    #1;
    total++;
    if ({frame_valid, frame_err, busy, frame_cnt, frame_data} !== '0) begin
      bad++;
      $display("FAIL reset_mid busy=%0b cnt=%0d data=%h required all zero", busy, frame_cnt, frame_data);
    end
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_cnt = 0;
    got_q.delete();
    send_frame(16'hBEEF, 1'b0, 1'b0);
    model_good(16'hBEEF);
    repeat (6) @(negedge clk);
    total++;
    if (got_q.size() != 1 || frame_data !== 16'hBEEF || frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL reset_mid_recover frames=%0d data=%h cnt=%0d required 1 frame beef cnt=1",
               got_q.size(), frame_data, frame_cnt);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random_frames();
    logic [FB-1:0] d;
    logic [FB-1:0] e;
    for (int i = 0; i < 25; i++) begin
      d = 16'($urandom);
      send_frame(d, 1'b0, 1'b1);
      model_good(d);
    end
    repeat (8) @(negedge clk);
    total++;
    if (got_q.size() != exp_q.size() || frame_cnt !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL random_count frames=%0d cnt=%0d required %0d cnt=%0d",
               got_q.size(), frame_cnt, exp_q.size(), exp_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e = exp_q[i];
      total++;
      if (got_q[i] !== e) begin
        bad++;
        $display("FAIL random_frame idx=%0d got=%h required %h", i, got_q[i], e);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

`ifdef STIM_LINK_RX_PARITY_EN
  task automatic test_parity();
    int e0;
    send_frame(16'h0001, 1'b0, 1'b0);
    model_good(16'h0001);
    repeat (6) @(negedge clk);
    total++;
    if (got_q.size() != 1 || frame_data !== 16'h0001 || frame_cnt !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL parity_good frames=%0d data=%h cnt=%0d required 1 frame 0001 cnt=%0d",
               got_q.size(), frame_data, frame_cnt, exp_cnt);
    end
    got_q.delete();
    e0 = n_err;
    send_frame(16'h0001, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    total++;
    if (n_err - e0 != 1 || got_q.size() != 0 || frame_cnt !== 8'(exp_cnt) || frame_data !== exp_data) begin
      bad++;
      $display("FAIL parity_bad err_pulses=%0d frames=%0d cnt=%0d data=%h required 1 err, cnt=%0d data=%h",
               n_err - e0, got_q.size(), frame_cnt, frame_data, exp_cnt, exp_data);
    end
    got_q.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_latency();
    test_stuck_link();
    test_back_to_back();
    test_short_frame();
    test_reset_mid();
    test_random_frames();
`ifdef STIM_LINK_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
